// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    SDR_INIT  = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int INIT_TIMEOUT_DEF  = 65536;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// N-flop single-bit synchroniser, async active-low reset to 0.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[N-2:0], d_i};
    end
  end

  assign q_o = ff_q[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release after PLL lock: SDRAM controller first, then CPU/system.
// Optional SDRAM init timeout is built when RESET_SEQ_TIMEOUT_EN is defined.
//
//   state     | meaning
//   WAIT_LOCK | all resets held, waiting for synchronised lock
//   STABILISE | lock seen, counting STABLE_CYCLES of continuous lock
//   SDR_INIT  | SDRAM released, waiting for sdr_init_done
//   RUN       | both resets released
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int INIT_TIMEOUT  = INIT_TIMEOUT_DEF
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdr_init_done,
  input  logic       lock_lost_clr,
  output logic       sdr_rst,
  output logic       sys_rst,
  output logic       lock_lost,
  output logic       init_timeout,
  output logic [1:0] seq_state
);

  localparam int STW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [STW-1:0] STAB_LAST = STW'(STABLE_CYCLES - 1);

  seq_state_t     state_q, state_d;
  logic [STW-1:0] stab_cnt_q, stab_cnt_d;
  logic           locked_s;
  logic           lost_set;
  logic           sdr_rst_q, sys_rst_q;
  logic           lock_lost_q;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int TMW = $clog2(INIT_TIMEOUT) + 1;
  localparam logic [TMW-1:0] TMO_LAST = TMW'(INIT_TIMEOUT - 1);

  logic [TMW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           tmo_hit;
  logic           init_timeout_q;
`else
  logic unused_init_timeout_param;
  assign unused_init_timeout_param = (INIT_TIMEOUT > 0);
`endif

  sync_bit #(
    .N (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (sys_clk),
    .rst_n_i (rst_n),
    .d_i     (pll_locked),
    .q_o     (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    lost_set   = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    tmo_cnt_d  = '0;
    tmo_hit    = 1'b0;
`endif

    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABILISE;
      end
      STABILISE: begin
        if (stab_cnt_q == STAB_LAST) begin
          state_d = SDR_INIT;
        end else begin
          stab_cnt_d = (stab_cnt_q == '1) ? stab_cnt_q : stab_cnt_q + 1'b1;
        end
      end
      SDR_INIT: begin
        if (sdr_init_done) begin
          state_d = RUN;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Re-run the whole stabilise window before releasing SDRAM again.
          state_d = STABILISE;
          tmo_hit = 1'b1;
        end else begin
          tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // Lock loss overrides every other transition.
    if (!locked_s && (state_q != WAIT_LOCK)) begin
      state_d    = WAIT_LOCK;
      lost_set   = 1'b1;
      stab_cnt_d = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
      tmo_cnt_d  = '0;
      tmo_hit    = 1'b0;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      sdr_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      // Decoding from state_d keeps the reset outputs glitch-free and aligned with state_q.
      sdr_rst_q  <= !((state_d == SDR_INIT) || (state_d == RUN));
      sys_rst_q  <= (state_d != RUN);
      if (lost_set) begin
        lock_lost_q <= 1'b1;
      end else if (lock_lost_clr) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q      <= '0;
      init_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_hit) init_timeout_q <= 1'b1;
    end
  end

  assign init_timeout = init_timeout_q;
`else
  assign init_timeout = 1'b0;
`endif

  assign sdr_rst   = sdr_rst_q;
  assign sys_rst   = sys_rst_q;
  assign lock_lost = lock_lost_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed + randomized bench for reset_sequencer against a timestamp-based reference model.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int TMO    = 64;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sdr_init_done = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       sdr_rst, sys_rst, lock_lost, init_timeout;
  logic [1:0] seq_state;

  int checks = 0;
  int failures = 0;

  // Reference model: edge index at which each milestone happened (-1 = not yet).
  int m_edge;
  int m_lock;
  int m_sdr;
  int m_sys;
  bit m_lost;
  bit m_tmo;
  bit hist[$];

  reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .INIT_TIMEOUT  (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sdr_init_done (sdr_init_done),
    .lock_lost_clr (lock_lost_clr),
    .sdr_rst       (sdr_rst),
    .sys_rst       (sys_rst),
    .lock_lost     (lock_lost),
    .init_timeout  (init_timeout),
    .seq_state     (seq_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_lock = -1;
    m_sdr  = -1;
    m_sys  = -1;
    m_lost = 1'b0;
    m_tmo  = 1'b0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
  endtask

  // The sequencer sees pll_locked SYNC edges late.
  task automatic model_edge(input bit pll, input bit done, input bit clr);
    bit seen;
    bit lost_evt;
    seen = hist.pop_front();
    hist.push_back(pll);
    lost_evt = 1'b0;
    if (!seen) begin
      if (m_lock >= 0) lost_evt = 1'b1;
      m_lock = -1;
      m_sdr  = -1;
      m_sys  = -1;
    end else if (m_lock < 0) begin
      m_lock = m_edge;
    end else if (m_sdr < 0) begin
      if (m_edge - m_lock == STABLE) m_sdr = m_edge;
    end else if (m_sys < 0) begin
      if (done) begin
        m_sys = m_edge;
      end
`ifdef RESET_SEQ_TIMEOUT_EN
      else if (m_edge - m_sdr == TMO) begin
        m_lock = m_edge;
        m_sdr  = -1;
        m_tmo  = 1'b1;
      end
`endif
    end
    if (lost_evt) m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
    m_edge++;
  endtask

  function automatic logic [1:0] exp_state();
    if (m_lock < 0) return 2'd0;
    if (m_sdr < 0)  return 2'd1;
    if (m_sys < 0)  return 2'd2;
    return 2'd3;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":sdr_rst"}, sdr_rst, (m_sdr < 0));
    chk({tag, ":sys_rst"}, sys_rst, (m_sys < 0));
    chk({tag, ":seq_state"}, seq_state, exp_state());
    chk({tag, ":lock_lost"}, lock_lost, m_lost);
    chk({tag, ":init_timeout"}, init_timeout, m_tmo);
    chk({tag, ":order"}, (sys_rst === 1'b0) && (sdr_rst !== 1'b0), 1'b0);
  endtask

  task automatic cycle(input bit pll, input bit done, input bit clr, input string tag);
    pll_locked    = pll;
    sdr_init_done = done;
    lock_lost_clr = clr;
    @(posedge sys_clk);
    model_edge(pll, done, clr);
    @(negedge sys_clk);
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ":sdr_rst"}, sdr_rst, 1'b1);
    chk({tag, ":sys_rst"}, sys_rst, 1'b1);
    chk({tag, ":lock_lost"}, lock_lost, 1'b0);
    chk({tag, ":init_timeout"}, init_timeout, 1'b0);
    chk({tag, ":seq_state"}, seq_state, 2'd0);
  endtask

  initial begin
    int sdr_fall;
    int sys_fall;
    int hi_at;
    bit pll;
    int drop_pct;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Lock at cycle 0, init_done pulse at cycle 30.
    sdr_fall = -1;
    sys_fall = -1;
    for (int c = 0; c < 36; c++) begin
      cycle(1'b1, (c == 30), 1'b0, "bringup");
      if (sdr_fall < 0 && sdr_rst === 1'b0) sdr_fall = c + 1;
      if (sys_fall < 0 && sys_rst === 1'b0) sys_fall = c + 1;
    end
    chk("sdr_fall_cycle", sdr_fall, 19);
    chk("sys_fall_cycle", sys_fall, 31);

    // One-cycle lock drop in RUN, then measure relock release.
    hi_at = -1;
    sdr_fall = -1;
    for (int j = 0; j < 30; j++) begin
      cycle((j != 0), 1'b0, 1'b0, "run_drop");
      if (hi_at < 0 && sdr_rst === 1'b1 && sys_rst === 1'b1) hi_at = j + 1;
      if (hi_at >= 0 && sdr_fall < 0 && sdr_rst === 1'b0) sdr_fall = j;
    end
    chk("resets_high_within_3", (hi_at >= 1) && (hi_at <= 3), 1'b1);
    chk("relock_sdr_fall", sdr_fall, 19);
    chk("lock_lost_after_drop", lock_lost, 1'b1);

    // Lock drop at stabilise counter 10: count restarts, no early release.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "unlock");
    sdr_fall = -1;
    for (int j = 0; j < 40; j++) begin
      cycle((j != 11), 1'b0, 1'b0, "stab_drop");
      if (sdr_fall < 0 && sdr_rst === 1'b0) sdr_fall = j + 1 - 12;
    end
    chk("stab_drop_release", sdr_fall, 19);

    // lock_lost clear alone, clear colliding with a new loss, clear alone again.
    cycle(1'b1, 1'b0, 1'b1, "clr_alone");
    chk("lock_lost_cleared", lock_lost, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, "loss_a");
    cycle(1'b0, 1'b0, 1'b0, "loss_b");
    cycle(1'b0, 1'b0, 1'b1, "loss_with_clr");
    chk("set_beats_clr", lock_lost, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, "idle");
    cycle(1'b0, 1'b0, 1'b1, "clr_again");
    chk("lock_lost_cleared_again", lock_lost, 1'b0);

    // Async reset in the middle of STABILISE with lock_lost set.
    repeat (8) cycle(1'b1, 1'b0, 1'b0, "relock");
    cycle(1'b0, 1'b0, 1'b0, "drop_c");
    cycle(1'b1, 1'b0, 1'b0, "drop_d");
    repeat (10) cycle(1'b1, 1'b0, 1'b0, "pre_rst");
    chk("lost_before_rst", lock_lost, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge sys_clk);
    check_reset_values("rst_held");
    rst_n = 1'b1;

    // Hold init_done low: waits forever, or times out and re-stabilises.
    for (int c = 0; c < 200; c++) cycle(1'b1, 1'b0, 1'b0, "no_init");
`ifdef RESET_SEQ_TIMEOUT_EN
    chk("init_timeout_sticky", init_timeout, 1'b1);
`else
    chk("init_wait_state", seq_state, 2'd2);
`endif
    cycle(1'b1, 1'b1, 1'b0, "init_late");

    // Randomized traffic with varying lock-drop rates.
    for (int seg = 0; seg < 6; seg++) begin
      drop_pct = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 4 : 15);
      for (int c = 0; c < 250; c++) begin
        pll = ($urandom_range(0, 99) >= drop_pct);
        cycle(pll, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the system PLL, in the sys_clk domain.
- Consumes the PLL lock indication and produces ordered, glitch-free synchronous reset releases. The SDRAM controller comes out of reset first; the CPU/system logic follows once SDRAM initialisation completes.
- Any loss of lock returns everything to reset and records the event.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the pll_locked synchroniser (legal ≥2).
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before sdr_rst releases (legal ≥1).
- INIT_TIMEOUT, 65536: sys_clk cycles allowed for sdr_init_done (used only with RESET_SEQ_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to sys_clk.
- sdr_init_done  in  1  SDRAM controller init complete, sys_clk domain, level.
- lock_lost_clr  in  1  single-cycle clear of lock_lost.
- sdr_rst  out  1  active-high synchronous reset to the SDRAM controller.
- sys_rst  out  1  active-high synchronous reset to CPU/system.
- lock_lost  out  1  sticky: lock dropped after leaving WAIT_LOCK.
- init_timeout  out  1  sticky: SDRAM init timed out.
- seq_state  out  2  current state encoding (debug).

Behaviour:
- Interface rules: one clock, sys_clk. Reset rst_n is asynchronous, active-low; assertion is async, deassertion is sampled on sys_clk.
- Reset values:
  - sdr_rst=1, sys_rst=1.
  - lock_lost=0, init_timeout=0.
  - seq_state=WAIT_LOCK (0).
  - All synchroniser flops and counters = 0.
- pll_locked passes through SYNC_STAGES flops, giving locked_s. No other logic samples pll_locked.
- States: WAIT_LOCK=0, STABILISE=1, SDR_INIT=2, RUN=3.
- Transitions:
  - WAIT_LOCK: locked_s=1 -> STABILISE, stable counter cleared to 0.
  - STABILISE: counter increments each cycle. When counter==STABLE_CYCLES-1 -> SDR_INIT.
  - SDR_INIT: sdr_init_done=1 -> RUN.
  - RUN: stays while locked_s=1.
  - Any state except WAIT_LOCK: locked_s=0 -> WAIT_LOCK. This has priority over every other transition.
- Outputs are registered, decoded from next_state:
  - sdr_rst=0 iff next_state ∈ {SDR_INIT, RUN}.
  - sys_rst=0 iff next_state==RUN.
- Latency: let T be the first cycle locked_s=1.
  - Enter STABILISE at T+1.
  - sdr_rst falls at T+1+STABLE_CYCLES.
  - sys_rst falls in the cycle after sdr_init_done is first sampled high.
- Lock loss: both resets are high the cycle after locked_s is sampled 0. lock_lost sets on any transition to WAIT_LOCK caused by locked_s=0.
- lock_lost_clr clears lock_lost. If set and clear occur in the same cycle, set wins.
- sdr_init_done is ignored outside SDR_INIT. If it is already high on entry, RUN is entered next cycle.
- sys_rst is never 0 while sdr_rst is 1 (invariant).
- Counter widths are $clog2(param)+1. Counters saturate and never wrap.
- rst_n asserted mid-sequence: immediate return to the reset values above.

Optional Feature:
- Macro: RESET_SEQ_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in SDR_INIT. After INIT_TIMEOUT cycles without sdr_init_done, the block goes to STABILISE, so sdr_rst reasserts and the full stabilise period repeats.
  - init_timeout sets (sticky) and is cleared only by rst_n.
  - Loss of lock still has priority.
- Undefined: SDR_INIT waits indefinitely. The init_timeout port remains, tied 0.

Decomposition:
- Package reset_seq_pkg contains:
  - state enum typedef seq_state_t (2 bits, encodings above);
  - localparam defaults for SYNC_STAGES, STABLE_CYCLES, INIT_TIMEOUT.
- One sub-module, sync_bit: a parameterised N-flop synchroniser with async active-low reset to 0, used for pll_locked.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=16, INIT_TIMEOUT=64):
- Release rst_n, raise pll_locked at cycle 0, hold sdr_init_done=0 -> sdr_rst falls at cycle 19 (T=2, T+1+16); sys_rst stays 1; seq_state=2.
- Continue and pulse sdr_init_done high at cycle 30 -> sys_rst falls at cycle 31; seq_state=3.
- In RUN, drop pll_locked for 1 cycle -> both resets high within 3 cycles; lock_lost=1; sequence restarts and sdr_rst falls again 19 cycles after lock returns.
- Drop pll_locked at STABILISE counter=10 -> return to WAIT_LOCK; counter restarts from 0 on relock (no early release).
- Assert lock_lost_clr in the same cycle as a new lock loss -> lock_lost stays 1. Assert it alone later -> lock_lost=0 next cycle.
- With RESET_SEQ_TIMEOUT_EN, never assert sdr_init_done -> 64 cycles after SDR_INIT entry: sdr_rst=1, init_timeout=1, seq_state=1; sdr_rst falls again 16 cycles later.
